// File: rtl/shift_add_mult_32bit.sv
// -----------------------------------------------------------------------------
// shift_add_mult_32bit
//   Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
//   The partial-sum addition is done by an external 2*WIDTH-bit adder. Each
//   RUN cycle this block drives the adder operands (accumulator and the
//   shifted multiplicand, or zero when the current multiplier bit is clear).
//   It registers the sum returned by the adder in the same cycle. After WIDTH
//   iterations the product is latched and done pulses for one cycle.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : request, accepted only while busy is low
//   multiplicand : operand A, sampled on an accepted start
//   multiplier   : operand B, sampled on an accepted start
//   busy         : high while RUN or DONE
//   done         : one-cycle pulse, product valid
//   product      : A*B, held until the next completed multiplication
//   add_a        : adder operand a (accumulator), zero outside RUN
//   add_b        : adder operand b (shifted multiplicand or zero), zero outside RUN
//   add_sum      : adder sum (combinational return path)
//   add_cout     : adder carry out, zero by construction
// -----------------------------------------------------------------------------
module shift_add_mult_32bit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   add_a,
  output logic [2*WIDTH-1:0]   add_b,
  input  logic [2*WIDTH-1:0]   add_sum,
  input  logic                 add_cout
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            accept_s;
  logic            last_s;
  logic [PW-1:0]   acc_r;
  logic [PW-1:0]   mcand_sh_r;
  logic [WIDTH-1:0] mplier_sh_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   product_r;
  logic            busy_r;
  logic            done_r;
  logic [PW-1:0]   add_a_s;
  logic [PW-1:0]   add_b_s;
  logic [PW-1:0]   sum_sat_s;

  // Next-state logic: accept on IDLE+start, finish after the last iteration.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == LAST_COUNT) begin
          state_s = ST_DONE;
          last_s  = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Adder operand drive: quiescent (zero) outside RUN.
  always_comb begin
    add_a_s = {PW{1'b0}};
    add_b_s = {PW{1'b0}};
    if (state_r == ST_RUN) begin
      add_a_s = acc_r;
      add_b_s = mplier_sh_r[0] ? mcand_sh_r : {PW{1'b0}};
    end else begin
      add_a_s = {PW{1'b0}};
      add_b_s = {PW{1'b0}};
    end
  end

  // A carry out cannot occur for unsigned partial products; if the adder
  // ever reports one, saturate instead of silently wrapping.
  always_comb begin
    sum_sat_s = add_sum;
    if (add_cout) begin
      sum_sat_s = {PW{1'b1}};
    end else begin
      sum_sat_s = add_sum;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand load on accept, shift/accumulate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {PW{1'b0}};
      mcand_sh_r  <= {PW{1'b0}};
      mplier_sh_r <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
    end else if (accept_s) begin
      acc_r       <= {PW{1'b0}};
      mcand_sh_r  <= {{WIDTH{1'b0}}, multiplicand};
      mplier_sh_r <= multiplier;
      count_r     <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      acc_r       <= sum_sat_s;
      mcand_sh_r  <= mcand_sh_r << 1;
      mplier_sh_r <= mplier_sh_r >> 1;
      count_r     <= count_r + CW'(1);
    end else begin
      acc_r       <= acc_r;
      mcand_sh_r  <= mcand_sh_r;
      mplier_sh_r <= mplier_sh_r;
      count_r     <= count_r;
    end
  end

  // Product capture on the DONE-entry edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= {PW{1'b0}};
    end else if (last_s) begin
      product_r <= sum_sat_s;
    end else begin
      product_r <= product_r;
    end
  end

  // Status flags registered from the next state so they align with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_RUN) || (state_s == ST_DONE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign add_a   = add_a_s;
  assign add_b   = add_b_s;

endmodule

// File: tb/tb_shift_add_mult_32bit.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult_32bit
//   Directed bench for shift_add_mult_32bit. Models the external 64-bit
//   adder, drives operands on the falling edge and samples there as well.
// -----------------------------------------------------------------------------
module tb_shift_add_mult_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_sum;
  logic        add_cout;

  int checks;
  int errors;
  logic cout_seen;

  shift_add_mult_32bit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  // External ripple-carry adder model.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky record of any adder carry out.
  always @(posedge clk) begin
    if (add_cout === 1'b1) cout_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows one multiplication from the first cycle after acceptance.
  task automatic run_check(input string tag, input logic [63:0] exp,
                           input logic [63:0] exp_prev, input int inject_at,
                           input logic [31:0] ia, input logic [31:0] ib);
    int cycles;
    int done_cnt;
    int done_at;
    cycles = 0;
    done_cnt = 0;
    done_at = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = cycles;
      end
      if (cycles == 5) check({tag, "_held"}, product, exp_prev);
      if (cycles == inject_at) begin
        start = 1'b1;
        multiplicand = ia;
        multiplier = ib;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, "_done_at"}, 64'(done_at), 64'd33);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_product"}, product, exp);
    check({tag, "_add_a_idle"}, add_a, 64'd0);
    check({tag, "_add_b_idle"}, add_b, 64'd0);
  endtask

  initial begin
    int done_cnt;
    checks = 0;
    errors = 0;
    cout_seen = 1'b0;
    start = 1'b0;
    multiplicand = 32'd0;
    multiplier = 32'd0;
    rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_add_a", add_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 * 5
    do_start(32'd3, 32'd5);
    run_check("t2", 64'h0000_0000_0000_000F, 64'd0, 0, 32'd0, 32'd0);

    // Asynchronous reset between clock edges clears product immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_done", 64'(done), 64'd0);
    check("t1_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Max operands; adder must never carry.
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("t3", 64'hFFFF_FFFE_0000_0001, 64'd0, 0, 32'd0, 32'd0);
    check("t3_cout", 64'(cout_seen), 64'd0);

    // Zero multiplier still runs the full iteration count.
    do_start(32'h1234_5678, 32'd0);
    run_check("t4", 64'd0, 64'hFFFF_FFFE_0000_0001, 0, 32'd0, 32'd0);

    // Start during RUN is ignored.
    do_start(32'd7, 32'd9);
    run_check("t5", 64'd63, 64'd0, 10, 32'd2, 32'd2);
    repeat (3) @(negedge clk);
    check("t5_stays_idle", 64'(busy), 64'd0);
    check("t5_product_stable", product, 64'd63);

    // Abort mid-run with reset.
    do_start(32'd100, 32'd100);
    repeat (15) @(negedge clk);
    check("t6_busy_mid", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_abort_busy", 64'(busy), 64'd0);
    check("t6_abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("t6_no_done", 64'(done_cnt), 64'd0);
    check("t6_product_after", product, 64'd0);
    do_start(32'd6, 32'd7);
    run_check("t6", 64'd42, 64'd0, 0, 32'd0, 32'd0);
    check("final_cout", 64'(cout_seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
